// File: rtl/ch376_spi_seq.sv
// CH376 SPI-mode command sequencer with ESP32/FPGA bus arbitration.
// Optional CH376_INT_WAIT_EN: after a data transaction, wait for INT# and auto-read GET_STATUS.
module ch376_spi_seq #(
    parameter int CLK_DIV     = 4,
    parameter int CMD_GAP     = 40,
    parameter int CS_IDLE     = 8,
    parameter int INT_TIMEOUT = 2500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] cmd,
    input  logic [7:0] tx_len,
    input  logic [7:0] rx_len,
    input  logic [7:0] tx_data,
    output logic       tx_take,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       done,
    output logic       esp_owner,
    output logic       int_pending,
    output logic [7:0] status,
    output logic       timeout,
    input  logic       esp_csn,
    input  logic       esp_clk,
    input  logic       esp_mosi,
    output logic       esp_miso,
    output logic       spi_csn,
    output logic       spi_clk,
    output logic       spi_mosi,
    input  logic       spi_miso,
    input  logic       ch_int_n
);
    typedef enum logic [3:0] {
        S_IDLE, S_ESP, S_SETUP, S_CMD, S_GAP, S_TX, S_RX, S_COOL
`ifdef CH376_INT_WAIT_EN
        , S_WAITINT
`endif
    } state_t;

    state_t      state;
    logic [1:0]  miso_sy, int_sy, csn_sy;
    logic        miso_s, int_s, csn_s, start_ok;
    logic        csn_r, clk_r, mosi_r, auto_r;
    logic [7:0]  sh, rsh, bcnt, cmd_r, tx_len_r, rx_len_r;
    logic [2:0]  bitn;
    logic [31:0] div_cnt, cnt;

    assign miso_s   = miso_sy[1];
    assign int_s    = int_sy[1];
    assign csn_s    = csn_sy[1];
    assign start_ok = (state == S_IDLE) && csn_s && start;

    // ESP32 gets a raw combinational path once it owns the bus
    assign spi_csn  = (state == S_ESP) ? esp_csn  : csn_r;
    assign spi_clk  = (state == S_ESP) ? esp_clk  : clk_r;
    assign spi_mosi = (state == S_ESP) ? esp_mosi : mosi_r;
    assign esp_miso = (state == S_ESP) ? spi_miso : 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            miso_sy <= 2'b11;
            int_sy  <= 2'b11;
            csn_sy  <= 2'b11;
        end else begin
            miso_sy <= {miso_sy[0], spi_miso};
            int_sy  <= {int_sy[0], ch_int_n};
            csn_sy  <= {csn_sy[0], esp_csn};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            csn_r       <= 1'b1;
            clk_r       <= 1'b0;
            mosi_r      <= 1'b1;
            sh          <= 8'hFF;
            rsh         <= '0;
            bitn        <= '0;
            div_cnt     <= '0;
            cnt         <= '0;
            bcnt        <= '0;
            cmd_r       <= '0;
            tx_len_r    <= '0;
            rx_len_r    <= '0;
            auto_r      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            tx_take     <= 1'b0;
            rx_valid    <= 1'b0;
            rx_data     <= '0;
            esp_owner   <= 1'b0;
            int_pending <= 1'b0;
            status      <= '0;
            timeout     <= 1'b0;
        end else begin
            done     <= 1'b0;
            tx_take  <= 1'b0;
            rx_valid <= 1'b0;
            timeout  <= 1'b0;

            if (start_ok)
                int_pending <= 1'b0;
            else if (!int_s)
                int_pending <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (!csn_s) begin
                        state     <= S_ESP;
                        esp_owner <= 1'b1;
                    end else if (start) begin
                        state    <= S_SETUP;
                        busy     <= 1'b1;
                        csn_r    <= 1'b0;
                        cnt      <= '0;
                        cmd_r    <= cmd;
                        tx_len_r <= tx_len;
                        rx_len_r <= rx_len;
                        auto_r   <= 1'b0;
                    end
                end

                S_ESP: begin
                    if (csn_s) begin
                        state     <= S_COOL;
                        esp_owner <= 1'b0;
                        cnt       <= '0;
                    end
                end

                S_SETUP: begin
                    if (cnt == CLK_DIV - 1) begin
                        state   <= S_CMD;
                        sh      <= cmd_r;
                        mosi_r  <= cmd_r[7];
                        bitn    <= '0;
                        div_cnt <= '0;
                        clk_r   <= 1'b0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                S_GAP: begin
                    if (cnt == CMD_GAP - 1) begin
                        bitn    <= '0;
                        div_cnt <= '0;
                        bcnt    <= '0;
                        if (tx_len_r != 8'd0) begin
                            state   <= S_TX;
                            sh      <= tx_data;
                            mosi_r  <= tx_data[7];
                            tx_take <= 1'b1;
                        end else if (rx_len_r != 8'd0) begin
                            state  <= S_RX;
                            sh     <= 8'hFF;
                            mosi_r <= 1'b1;
                        end else begin
                            state  <= S_COOL;
                            csn_r  <= 1'b1;
                            mosi_r <= 1'b1;
                            cnt    <= '0;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                S_CMD, S_TX, S_RX: begin
                    if (div_cnt != CLK_DIV - 1) begin
                        div_cnt <= div_cnt + 32'd1;
                    end else begin
                        div_cnt <= '0;
                        if (!clk_r) begin
                            // rising edge: sample MISO
                            clk_r <= 1'b1;
                            rsh   <= {rsh[6:0], miso_s};
                            if (state == S_RX && bitn == 3'd7) begin
                                if (auto_r)
                                    status <= {rsh[6:0], miso_s};
                                else begin
                                    rx_data  <= {rsh[6:0], miso_s};
                                    rx_valid <= 1'b1;
                                end
                            end
                        end else begin
                            clk_r <= 1'b0;
                            if (bitn != 3'd7) begin
                                bitn   <= bitn + 3'd1;
                                sh     <= {sh[6:0], 1'b1};
                                mosi_r <= sh[6];
                            end else begin
                                bitn <= '0;
                                case (state)
                                    S_CMD: begin
                                        state <= S_GAP;
                                        cnt   <= '0;
                                    end
                                    S_TX: begin
                                        if (bcnt + 8'd1 != tx_len_r) begin
                                            bcnt    <= bcnt + 8'd1;
                                            sh      <= tx_data;
                                            mosi_r  <= tx_data[7];
                                            tx_take <= 1'b1;
                                        end else if (rx_len_r != 8'd0) begin
                                            state  <= S_RX;
                                            bcnt   <= '0;
                                            sh     <= 8'hFF;
                                            mosi_r <= 1'b1;
                                        end else begin
                                            state  <= S_COOL;
                                            csn_r  <= 1'b1;
                                            mosi_r <= 1'b1;
                                            cnt    <= '0;
                                        end
                                    end
                                    default: begin
                                        if (bcnt + 8'd1 != rx_len_r) begin
                                            bcnt <= bcnt + 8'd1;
                                        end else begin
                                            state  <= S_COOL;
                                            csn_r  <= 1'b1;
                                            mosi_r <= 1'b1;
                                            cnt    <= '0;
                                        end
                                    end
                                endcase
                            end
                        end
                    end
                end

                S_COOL: begin
                    csn_r <= 1'b1;
                    clk_r <= 1'b0;
                    if (cnt == CS_IDLE - 1) begin
`ifdef CH376_INT_WAIT_EN
                        if (busy && !auto_r && (tx_len_r != 8'd0 || rx_len_r != 8'd0)) begin
                            state <= S_WAITINT;
                            cnt   <= '0;
                        end else
`endif
                        begin
                            state <= S_IDLE;
                            if (busy) begin
                                done <= 1'b1;
                                busy <= 1'b0;
                            end
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

`ifdef CH376_INT_WAIT_EN
                S_WAITINT: begin
                    if (!int_s) begin
                        // automatic GET_STATUS: one command, one read byte into status
                        state    <= S_SETUP;
                        csn_r    <= 1'b0;
                        cnt      <= '0;
                        cmd_r    <= 8'h22;
                        tx_len_r <= 8'd0;
                        rx_len_r <= 8'd1;
                        auto_r   <= 1'b1;
                    end else if (cnt == INT_TIMEOUT - 1) begin
                        state   <= S_IDLE;
                        timeout <= 1'b1;
                        status  <= 8'hFF;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
`endif

                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
